gemm_c_reader: RTL
==================

# gemm_c_reader

Result-drain block for the GEMM accelerator. It is the reader counterpart to the accelerator's output-SRAM writer. After a GeMM completes, it reads the tiled output memory C, where each word holds one M×N tile of OutDataWidth-bit results. It then serialises the results as a row-major element stream over a valid/ready interface to the host/DMA side, undoing the tile packing that the accelerator writes.

## Interface
Parameters:
- OutDataWidth, 32, width of one C element
- M, 4, tile rows per C word
- N, 4, tile columns per C word
- AddrWidth, 6, C SRAM address width
- SizeAddrWidth, 8, width of matrix size inputs

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  start pulse; sampled only in IDLE
- M_size_i  in  SizeAddrWidth  matrix rows M_i; latched at start
- N_size_i  in  SizeAddrWidth  matrix columns N_i; latched at start
- sram_c_addr_o  out  AddrWidth  C SRAM read address
- sram_c_rdata_i  in  OutDataWidth*M*N  C SRAM read data; 1-cycle registered read
- out_data_o  out  OutDataWidth  streamed element, signed
- out_valid_o  out  1  element valid
- out_ready_i  in  1  consumer ready
- out_last_o  out  1  final element of the matrix
- busy_o  out  1  drain in progress
- done_o  out  1  one-cycle completion pulse

## Operation
- C layout:
  - Tile word address = (m/M)*(N_i/N) + n/N.
  - Element (m,n) sits in lane (m%M)*N + n%N, at bits [lane*OutDataWidth +: OutDataWidth].
- Tile counts: TM = M_i/M and TN = N_i/N, both floored. Remainder rows and columns are ignored.
- Default output order: for m in 0..TM*M-1, for n in 0..TN*N-1, emit element (m,n).
  - Each row segment of N elements comes from one word.
  - Each word is therefore re-read M times, once per row.
- FSM states:
  - IDLE: on start_i, latch sizes and clear counters. If TM==0 or TN==0, go to DONE; otherwise go to FETCH.
  - FETCH: drive the segment address → LOAD.
  - LOAD: capture sram_c_rdata_i into the word buffer and set lane = (m%M)*N → STREAM.
  - STREAM: out_valid_o=1. On each handshake, advance n. After N handshakes, go to FETCH. After the final handshake, go to DONE.
  - DONE: done_o=1 for one cycle → IDLE.
- Handshake rules:
  - out_data_o and out_last_o are held stable while valid && !ready.
  - out_valid_o never deasserts without a handshake.
- start_i is ignored outside IDLE.
- Address arithmetic is modulo 2^AddrWidth. Configurations with TM*TN > 2^AddrWidth wrap, and the caller must avoid them.

## Timing
- Reset values: sram_c_addr_o=0, out_data_o=0, out_valid_o=0, out_last_o=0, busy_o=0, done_o=0. FSM returns to IDLE.
- Start latency:
  - start_i sampled at edge 0.
  - Cycle 1: FETCH.
  - Cycle 2: LOAD.
  - Cycle 3: first out_valid_o.
- Each segment change costs 2 bubble cycles (FETCH, LOAD).
- With out_ready_i tied high, a full drain takes TM*M*TN*(N+2) cycles plus 2 cycles (start to first FETCH, plus DONE).
- done_o asserts in the cycle after the last handshake. busy_o is high from the cycle after start until DONE, inclusive.
- Zero-tile start: done_o pulses in the cycle after start, and no beats are emitted.
- Reset mid-stream: the stream is abandoned with no last beat. All outputs return to reset values in the next cycle.

## Configuration
- GEMM_C_READER_TILE_ORDER_EN
  - Defined: raw tile order. Words are read in addresses 0..TM*TN-1, each exactly once. Lanes 0..M*N-1 are emitted per word. FETCH/LOAD occurs once per M*N beats.
  - Undefined: row-major reorder as described above.

## Structure
- gemm_c_reader_pkg holds:
  - the FSM state enum typedef;
  - the lane index width constant, $clog2(M*N);
  - the address function for tile word (m/M)*TN + n/N.
- One sub-module, gemm_c_reader_addr_gen: m/n/lane counters, segment-end and last detection, and address generation. The top-level block holds the FSM, word buffer and lane mux.

## Test plan
- Basic 4×4 drain:
  - Stimulus: M_i=N_i=4, word 0 lanes i = 100+i, ready tied high.
  - Response: 16 beats with values 100..115. First valid 3 cycles after start. out_last_o on beat 16, done_o on the following cycle.
- 8×8 reorder:
  - Stimulus: M_i=N_i=8, element (m,n) = m*8+n packed per the tile layout.
  - Response: stream 0..63 ascending. Address sequence 0,1 repeated 4 times, then 2,3 repeated 4 times.
- Backpressure:
  - Stimulus: 8×8, ready pattern 1,0,0,1 repeating.
  - Response: data stable while stalled. Exactly 64 beats, no loss or duplicates.
- Undersize:
  - Stimulus: M_i=3, N_i=8.
  - Response: done_o pulse 1 cycle after start. out_valid_o never asserts.
- Reset mid-stream:
  - Stimulus: assert rst_i after 5 beats.
  - Response: all outputs 0 the next cycle. A fresh start restarts from address 0 with value 0.
- Tile order (GEMM_C_READER_TILE_ORDER_EN defined):
  - Stimulus: 8×8.
  - Response: addresses 0,1,2,3, each once. 16 beats per word in lane order.

Source files
------------

// File: rtl/gemm_c_reader_pkg.sv
// Shared types and helpers for the GEMM C-matrix drain path.
package gemm_c_reader_pkg;

    localparam int TILE_M = 4;
    localparam int TILE_N = 4;
    localparam int LANE_W = $clog2(TILE_M * TILE_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_e;

    // Word address of the tile holding row-tile m_tile, column-tile n_tile.
    function automatic int unsigned tile_addr(input int unsigned m_tile,
                                              input int unsigned n_tile,
                                              input int unsigned tn);
        return m_tile * tn + n_tile;
    endfunction

endpackage

// File: rtl/gemm_c_reader_addr_gen.sv
// Element/word counters, segment-end and last-beat detection, C SRAM address.
// GEMM_C_READER_TILE_ORDER_EN selects raw tile order instead of row-major reorder.
module gemm_c_reader_addr_gen
    import gemm_c_reader_pkg::*;
#(
    parameter int M             = TILE_M,
    parameter int N             = TILE_N,
    parameter int AddrWidth     = 6,
    parameter int SizeAddrWidth = 8,
    parameter int LaneW         = LANE_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     adv_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    output logic [AddrWidth-1:0]     addr_o,
    output logic [LaneW-1:0]         lane_start_o,
    output logic                     seg_end_o,
    output logic                     last_o
);

    localparam int SW = SizeAddrWidth;

    logic [SW-1:0] tm_q, tn_q;
    logic [31:0]   addr_full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tm_q <= '0;
            tn_q <= '0;
        end else if (clr_i) begin
            tm_q <= SW'(int'(M_size_i) / M);
            tn_q <= SW'(int'(N_size_i) / N);
        end
    end

`ifdef GEMM_C_READER_TILE_ORDER_EN
    logic [2*SW-1:0] w_q, w_d;
    logic [LaneW-1:0] l_q, l_d;

    always_comb begin
        seg_end_o    = (int'(l_q) == M * N - 1);
        last_o       = seg_end_o && (int'(w_q) == int'(tm_q) * int'(tn_q) - 1);
        lane_start_o = '0;
        addr_full    = 32'(w_q);
        addr_o       = addr_full[AddrWidth-1:0];
        w_d          = w_q;
        l_d          = l_q;
        if (clr_i) begin
            w_d = '0;
            l_d = '0;
        end else if (adv_i) begin
            if (last_o) begin
                w_d = '0;
                l_d = '0;
            end else if (seg_end_o) begin
                w_d = w_q + (2*SW)'(1);
                l_d = '0;
            end else begin
                l_d = l_q + LaneW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_q <= '0;
            l_q <= '0;
        end else begin
            w_q <= w_d;
            l_q <= l_d;
        end
    end
`else
    logic [SW-1:0] m_q, m_d, n_q, n_d;
    logic          row_end;

    always_comb begin
        row_end      = (int'(n_q) == int'(tn_q) * N - 1);
        seg_end_o    = ((int'(n_q) % N) == N - 1);
        last_o       = row_end && (int'(m_q) == int'(tm_q) * M - 1);
        lane_start_o = LaneW'((int'(m_q) % M) * N);
        addr_full    = tile_addr(int'(m_q) / M, int'(n_q) / N, int'(tn_q));
        addr_o       = addr_full[AddrWidth-1:0];
        m_d          = m_q;
        n_d          = n_q;
        if (clr_i) begin
            m_d = '0;
            n_d = '0;
        end else if (adv_i) begin
            if (last_o) begin
                m_d = '0;
                n_d = '0;
            end else if (row_end) begin
                m_d = m_q + SW'(1);
                n_d = '0;
            end else begin
                n_d = n_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_q <= '0;
            n_q <= '0;
        end else begin
            m_q <= m_d;
            n_q <= n_d;
        end
    end
`endif

endmodule

// File: rtl/gemm_c_reader.sv
// Drains the tiled C output SRAM as a valid/ready element stream.
// GEMM_C_READER_TILE_ORDER_EN (in the address generator) selects raw tile order.
module gemm_c_reader
    import gemm_c_reader_pkg::*;
#(
    parameter int OutDataWidth  = 32,
    parameter int M             = 4,
    parameter int N             = 4,
    parameter int AddrWidth     = 6,
    parameter int SizeAddrWidth = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [SizeAddrWidth-1:0]       M_size_i,
    input  logic [SizeAddrWidth-1:0]       N_size_i,
    output logic [AddrWidth-1:0]           sram_c_addr_o,
    input  logic [OutDataWidth*M*N-1:0]    sram_c_rdata_i,
    output logic signed [OutDataWidth-1:0] out_data_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic                           out_last_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int LaneW = $clog2(M * N);

    state_e                      state_q, state_d;
    logic [OutDataWidth*M*N-1:0] word_q;
    logic [LaneW-1:0]            lane_q, lane_start;
    logic                        seg_end, last, hs, clr, zero_tiles;

    assign zero_tiles = (int'(M_size_i) < M) || (int'(N_size_i) < N);
    assign clr        = (state_q == S_IDLE) && start_i;
    assign hs         = (state_q == S_STREAM) && out_ready_i;

    gemm_c_reader_addr_gen #(
        .M             (M),
        .N             (N),
        .AddrWidth     (AddrWidth),
        .SizeAddrWidth (SizeAddrWidth),
        .LaneW         (LaneW)
    ) u_addr_gen (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (clr),
        .adv_i        (hs),
        .M_size_i     (M_size_i),
        .N_size_i     (N_size_i),
        .addr_o       (sram_c_addr_o),
        .lane_start_o (lane_start),
        .seg_end_o    (seg_end),
        .last_o       (last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = zero_tiles ? S_DONE : S_FETCH;
            S_FETCH:  state_d = S_LOAD;
            S_LOAD:   state_d = S_STREAM;
            S_STREAM: begin
                if (hs && last)         state_d = S_DONE;
                else if (hs && seg_end) state_d = S_FETCH;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Word buffer and lane pointer are datapath only; outputs are gated by state.
    always_ff @(posedge clk_i) begin
        if (state_q == S_LOAD) begin
            word_q <= sram_c_rdata_i;
            lane_q <= lane_start;
        end else if (hs) begin
            lane_q <= lane_q + LaneW'(1);
        end
    end

    always_comb begin
        out_valid_o = (state_q == S_STREAM);
        out_data_o  = out_valid_o ? word_q[int'(lane_q)*OutDataWidth +: OutDataWidth] : '0;
        out_last_o  = out_valid_o && last;
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
    end

endmodule
